// File: rtl/rom_uart_loader_pkg.sv
// Shared definitions for the UART program loader: sync byte and FSM encodings.
// Imported by the byte receiver and the loader top.
package rom_uart_loader_pkg;

   localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

   typedef enum logic [2:0] {
      IDLE,
      CNT_LO,
      CNT_HI,
      DATA,
      CSUM,
      DONE,
      ERR
   } loader_state_e;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_DONE
   } rx_state_e;

endpackage

// File: rtl/rom_uart_loader_uart_rx.sv
// 8N1 UART byte receiver: two-flop synchroniser, mid-bit sampling, framing check.
// byte_valid_o / frame_err_o pulse for one cycle, one cycle after the stop-bit sample.
module uart_rx_byte
   import rom_uart_loader_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   output logic       frame_err_o
);

   localparam int CW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2);
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   rx_state_e     state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic [2:0]    bit_idx, bit_next;
   logic [7:0]    shift, shift_next;
   logic          stop_bit, stop_next;
   logic          rx_meta, rx_sync, rx_prev;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta  <= 1'b1;
         rx_sync  <= 1'b1;
         rx_prev  <= 1'b1;
         state    <= RX_IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shift    <= '0;
         stop_bit <= 1'b1;
      end else begin
         rx_meta  <= rx_i;
         rx_sync  <= rx_meta;
         rx_prev  <= rx_sync;
         state    <= state_next;
         cnt      <= cnt_next;
         bit_idx  <= bit_next;
         shift    <= shift_next;
         stop_bit <= stop_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt + 1'b1;
      bit_next   = bit_idx;
      shift_next = shift;
      stop_next  = stop_bit;
      case (state)
         RX_IDLE: begin
            cnt_next = '0;
            if (rx_prev && !rx_sync) state_next = RX_START;
         end
         RX_START: begin
            // A line that is high again at mid-start-bit was a glitch.
            if (cnt == HALF) begin
               cnt_next   = '0;
               state_next = rx_sync ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (cnt == LAST) begin
               cnt_next   = '0;
               shift_next = {rx_sync, shift[7:1]};
               bit_next   = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = RX_STOP;
            end
         end
         RX_STOP: begin
            if (cnt == LAST) begin
               cnt_next   = '0;
               stop_next  = rx_sync;
               state_next = RX_DONE;
            end
         end
         RX_DONE: begin
            cnt_next   = '0;
            state_next = RX_IDLE;
         end
         default: state_next = RX_IDLE;
      endcase
   end

   assign byte_o       = shift;
   assign byte_valid_o = (state == RX_DONE) && stop_bit;
   assign frame_err_o  = (state == RX_DONE) && !stop_bit;

endmodule

// File: rtl/rom_uart_loader.sv
// Loads a framed program image from UART into instruction ROM, word by word,
// holding the core in reset during the load and flagging completion or error.
module rom_uart_loader
   import rom_uart_loader_pkg::*;
#(
   parameter int          CLK_FREQ     = 100000000,
   parameter int          BAUD         = 115200,
   parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
   parameter int          TIMEOUT_CLKS = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_rx_i,
   output logic        w_en_o,
   output logic [31:0] w_addr_o,
   output logic [31:0] w_data_o,
   output logic [3:0]  w_sel_o,
   output logic        core_hold_o,
   output logic        load_done_o,
   output logic        load_err_o
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   logic [7:0] rx_byte;
   logic       byte_valid, frame_err;

   uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk          (clk),
      .rst          (rst),
      .rx_i         (uart_rx_i),
      .byte_o       (rx_byte),
      .byte_valid_o (byte_valid),
      .frame_err_o  (frame_err)
   );

   loader_state_e state, state_next;
   logic [7:0]    cnt_lo;
   logic [15:0]   count;
   logic [15:0]   word_cnt;
   logic [15:0]   word_cnt_inc;
   logic [1:0]    byte_idx;
   logic [31:0]   asm_word;
   logic [7:0]    csum;
   logic [31:0]   to_cnt;
   logic          active, timeout_hit, is_sync;

   assign active       = (state == CNT_LO) || (state == CNT_HI) || (state == DATA) || (state == CSUM);
   assign timeout_hit  = to_cnt >= 32'(TIMEOUT_CLKS);
   assign word_cnt_inc = word_cnt + 16'd1;
   assign is_sync      = rx_byte == LOADER_SYNC_BYTE;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, ERR: if (byte_valid && is_sync) state_next = CNT_LO;
         CNT_LO:          if (byte_valid) state_next = CNT_HI;
         CNT_HI:          if (byte_valid) state_next = ({rx_byte, cnt_lo} == 16'd0) ? CSUM : DATA;
         DATA:            if (byte_valid && byte_idx == 2'd3 && word_cnt_inc == count) state_next = CSUM;
         CSUM:            if (byte_valid) state_next = (rx_byte == csum) ? DONE : ERR;
         default:         state_next = IDLE;
      endcase
      if (active && (frame_err || timeout_hit)) state_next = ERR;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_en_o      <= 1'b0;
         w_addr_o    <= BASE_ADDR;
         w_data_o    <= '0;
         core_hold_o <= 1'b0;
         load_done_o <= 1'b0;
         load_err_o  <= 1'b0;
         cnt_lo      <= '0;
         count       <= '0;
         word_cnt    <= '0;
         byte_idx    <= '0;
         asm_word    <= '0;
         csum        <= '0;
         to_cnt      <= '0;
      end else begin
         w_en_o <= 1'b0;
         // Address advances the cycle after the strobe so the write sees the old one.
         if (w_en_o) w_addr_o <= w_addr_o + 32'd4;

         if (!active || byte_valid)  to_cnt <= '0;
         else if (!timeout_hit)      to_cnt <= to_cnt + 32'd1;

         if (byte_valid) begin
            case (state)
               IDLE, DONE, ERR: begin
                  if (is_sync) begin
                     core_hold_o <= 1'b1;
                     load_done_o <= 1'b0;
                     load_err_o  <= 1'b0;
                     w_addr_o    <= BASE_ADDR;
                     csum        <= '0;
                     word_cnt    <= '0;
                     byte_idx    <= '0;
                  end
               end
               CNT_LO: cnt_lo <= rx_byte;
               CNT_HI: count  <= {rx_byte, cnt_lo};
               DATA: begin
                  asm_word <= {rx_byte, asm_word[31:8]};
                  csum     <= csum ^ rx_byte;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     w_en_o   <= 1'b1;
                     w_data_o <= {rx_byte, asm_word[31:8]};
                     word_cnt <= word_cnt_inc;
                  end
               end
               default: ;
            endcase
         end

         if (state_next == DONE && state != DONE) begin
            load_done_o <= 1'b1;
            core_hold_o <= 1'b0;
         end
         if (state_next == ERR && state != ERR) load_err_o <= 1'b1;
      end
   end

   assign w_sel_o = w_en_o ? 4'b1111 : 4'b0000;

endmodule
